// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Byte-address bits that must be zero for a word access.
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  // True when an address is outside memory or not word aligned.
  function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] limit);
    return (addr >= limit) || ((addr & ALIGN_MASK) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - loadable, clearable busy-cycle counter with expire flag
module mem_arb_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expire
);

  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles, parking at the terminal value so expire stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != TERM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT  = 32'h0001_0000,
  parameter int          TIMEOUT    = 16,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_done,
  output logic        instr_segv,
  output logic        wait_instr,
  input  logic        data_ld,
  input  logic        data_st,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        data_segv,
  output logic        wait_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);
  localparam int             TW         = $clog2(TIMEOUT + 1);

  state_t        state;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic          data_req;
  logic          grant_d;
  logic          grant_i;
  logic          data_fault;
  logic          instr_fault;
  logic          busy;
  logic          tmo_expire;

  assign data_req    = data_ld | data_st;
  assign data_fault  = (data_ld & data_st) | addr_fault(data_addr, MEM_LIMIT);
  assign instr_fault = addr_fault(instr_addr, MEM_LIMIT);
  assign busy        = (state == BUSY_I) || (state == BUSY_D);

  assign wait_instr  = instr_req & ~instr_done;
  assign wait_data   = data_req & ~data_done;

  // Data normally wins; a fetch that has lost STARVE_MAX times in a row goes first.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (data_req && !(instr_req && (starve_cnt == STARVE_TOP))) begin
        grant_d = 1'b1;
      end else if (instr_req) begin
        grant_i = 1'b1;
      end
    end
  end

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state == RESP),
    .load     (grant_d | grant_i),
    .load_val ('0),
    .en       (busy),
    .expire   (tmo_expire)
  );

  // Request sequencer: grant and latch, wait for mem_ready or timeout, pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      starve_cnt  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr_rdata <= '0;
      data_rdata  <= '0;
      instr_done  <= 1'b0;
      instr_segv  <= 1'b0;
      data_done   <= 1'b0;
      data_segv   <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      instr_segv <= 1'b0;
      data_done  <= 1'b0;
      data_segv  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= OWN_D;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            if (instr_req && (starve_cnt != STARVE_TOP)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            if (data_fault) begin
              state     <= RESP;
              data_done <= 1'b1;
              data_segv <= 1'b1;
              if (!data_st) begin
                data_rdata <= '0;
              end
            end else begin
              state   <= BUSY_D;
              mem_req <= 1'b1;
              mem_we  <= data_st;
            end
          end else if (grant_i) begin
            owner      <= OWN_I;
            mem_addr   <= instr_addr;
            starve_cnt <= '0;
            if (instr_fault) begin
              state       <= RESP;
              instr_done  <= 1'b1;
              instr_segv  <= 1'b1;
              instr_rdata <= '0;
            end else begin
              state   <= BUSY_I;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready || tmo_expire) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (owner == OWN_D) begin
              data_done <= 1'b1;
              data_segv <= ~mem_ready;
              if (!mem_we) begin
                data_rdata <= mem_ready ? mem_rdata : 32'd0;
              end
            end else begin
              instr_done  <= 1'b1;
              instr_segv  <= ~mem_ready;
              instr_rdata <= mem_ready ? mem_rdata : 32'd0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
